// File: rtl/banco_registros_param_pkg.sv
// Shared definitions for the clocked register bank: default geometry and the
// clear-sequencer state encoding.
package banco_registros_param_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    // One bit is enough for the two-state clear/idle sequencer.
    typedef logic [0:0] br_state_t;

    localparam br_state_t ST_CLEAR = 1'b0;
    localparam br_state_t ST_IDLE  = 1'b1;

endpackage

// File: rtl/banco_registros_param_br_read_mux.sv
// One combinational read port: forces zero while not ready or for entry 0,
// forwards the in-flight write on an address match, otherwise returns storage.
module br_read_mux
    import banco_registros_param_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              ready,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    // Priority: not-ready blanking, then hardwired zero, then bypass.
    always_comb begin
        rd_data = mem_data;
        if (!ready) begin
            rd_data = '0;
        end else if ((ZERO_REG != 0) && (rd_addr == '0)) begin
            rd_data = '0;
        end else if ((BYPASS != 0) && wr_en && (rd_addr == wr_addr)) begin
            rd_data = wr_data;
        end
    end

endmodule

// File: rtl/banco_registros_param.sv
// Parametrised register bank with NUM_RD combinational read ports, one
// synchronous write port and a sequencer that zeroes every entry after reset.
module banco_registros_param
    import banco_registros_param_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   R_register,
    output logic [NUM_RD*DATA_W-1:0]   R_data,
    input  logic [ADDR_W-1:0]          W_register,
    input  logic [DATA_W-1:0]          W_data,
    input  logic                       RegEn,
    input  logic                       Clr,
    output logic                       Ready,
    output logic                       Wr_drop
);

    localparam int              DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W + 1)'(1);

    br_state_t         state_reg, state_next;
    logic [ADDR_W:0]   clr_ptr_reg, clr_ptr_next;
    logic              wr_drop_reg, wr_drop_next;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              user_wr;

    assign Ready   = (state_reg == ST_IDLE);
    assign Wr_drop = wr_drop_reg;

    // Writes to entry 0 vanish silently when it is hardwired; no drop pulse.
    assign user_wr = RegEn && !((ZERO_REG != 0) && (W_register == '0));

    // The clear sequencer and user writes share the single array write port.
    always_comb begin
        state_next   = state_reg;
        clr_ptr_next = clr_ptr_reg;
        wr_drop_next = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = W_register;
        mem_wdata    = W_data;
        case (state_reg)
            ST_CLEAR: begin
                mem_we       = 1'b1;
                mem_waddr    = clr_ptr_reg[ADDR_W-1:0];
                mem_wdata    = '0;
                clr_ptr_next = clr_ptr_reg + PTR_ONE;
                wr_drop_next = RegEn;
                if (clr_ptr_reg == LAST_PTR) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                // A write on the Clr edge still lands; the sweep then wipes it.
                mem_we = user_wr;
                if (Clr) begin
                    state_next   = ST_CLEAR;
                    clr_ptr_next = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_CLEAR;
            clr_ptr_reg <= '0;
            wr_drop_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            clr_ptr_reg <= clr_ptr_next;
            wr_drop_reg <= wr_drop_next;
        end
    end

    // Storage is never reset; the sequencer is what makes it zero.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] rd_addr;
            assign rd_addr = R_register[gi*ADDR_W +: ADDR_W];

            br_read_mux #(
                .DATA_W   (DATA_W),
                .ADDR_W   (ADDR_W),
                .ZERO_REG (ZERO_REG),
                .BYPASS   (BYPASS)
            ) u_read_mux (
                .ready    (Ready),
                .rd_addr  (rd_addr),
                .mem_data (mem[rd_addr]),
                .wr_en    (RegEn),
                .wr_addr  (W_register),
                .wr_data  (W_data),
                .rd_data  (R_data[gi*DATA_W +: DATA_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_banco_registros_param.sv
// Scoreboard bench for banco_registros_param: three instances (default,
// no-bypass, 4-port/8-entry) driven by directed vectors.
module tb_banco_registros_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // u0: default parameters
    logic [9:0]  r_reg0;
    logic [63:0] r_data0;
    logic [4:0]  w_reg0;
    logic [31:0] w_data0;
    logic        regen0, clr0, ready0, wr_drop0;

    // u1: BYPASS = 0
    logic [9:0]  r_reg1;
    logic [63:0] r_data1;
    logic [4:0]  w_reg1;
    logic [31:0] w_data1;
    logic        regen1, clr1, ready1, wr_drop1;

    // u2: ADDR_W = 3, NUM_RD = 4
    logic [11:0]  r_reg2;
    logic [127:0] r_data2;
    logic [2:0]   w_reg2;
    logic [31:0]  w_data2;
    logic         regen2, clr2, ready2, wr_drop2;

    banco_registros_param u0 (
        .clk(clk), .rst(rst), .R_register(r_reg0), .R_data(r_data0),
        .W_register(w_reg0), .W_data(w_data0), .RegEn(regen0), .Clr(clr0),
        .Ready(ready0), .Wr_drop(wr_drop0)
    );

    banco_registros_param #(.BYPASS(0)) u1 (
        .clk(clk), .rst(rst), .R_register(r_reg1), .R_data(r_data1),
        .W_register(w_reg1), .W_data(w_data1), .RegEn(regen1), .Clr(clr1),
        .Ready(ready1), .Wr_drop(wr_drop1)
    );

    banco_registros_param #(.ADDR_W(3), .NUM_RD(4)) u2 (
        .clk(clk), .rst(rst), .R_register(r_reg2), .R_data(r_data2),
        .W_register(w_reg2), .W_data(w_data2), .RegEn(regen2), .Clr(clr2),
        .Ready(ready2), .Wr_drop(wr_drop2)
    );

    // sig: 0 = R_data[port], 1 = Ready, 2 = Wr_drop
    typedef struct packed {
        logic [127:0] name;
        logic [1:0]   dut;
        logic [1:0]   sig;
        logic [1:0]   port;
        logic [31:0]  exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input logic [127:0] name, input int dut, input int sig,
                       input int port, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.dut  = 2'(dut);
        e.sig  = 2'(sig);
        e.port = 2'(port);
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    function automatic logic [31:0] actual(input exp_t e);
        logic [31:0] a;
        int          idx;
        a   = '0;
        idx = 32 * int'(e.port);
        case (e.dut)
            2'd0: case (e.sig)
                2'd0:    a = r_data0[idx +: 32];
                2'd1:    a = {31'b0, ready0};
                default: a = {31'b0, wr_drop0};
            endcase
            2'd1: case (e.sig)
                2'd0:    a = r_data1[idx +: 32];
                2'd1:    a = {31'b0, ready1};
                default: a = {31'b0, wr_drop1};
            endcase
            default: case (e.sig)
                2'd0:    a = r_data2[idx +: 32];
                2'd1:    a = {31'b0, ready2};
                default: a = {31'b0, wr_drop2};
            endcase
        endcase
        return a;
    endfunction

    // Monitor: drains every expectation queued for the current cycle.
    initial begin : monitor
        exp_t        e;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                a = actual(e);
                n_checks++;
                if (a === e.exp) begin
                    n_pass++;
                    $display("ok   %0s dut%0d sig%0d port%0d = %h", e.name, e.dut, e.sig, e.port, a);
                end else begin
                    $display("FAIL %0s dut%0d sig%0d port%0d: got %h expected %h",
                             e.name, e.dut, e.sig, e.port, a, e.exp);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        regen0 = 1'b0; clr0 = 1'b0;
        regen1 = 1'b0; clr1 = 1'b0;
        regen2 = 1'b0; clr2 = 1'b0;
    endtask

    task automatic ready_sweep();
        for (int n = 0; n <= 32; n++) begin
            chk("ready_u0", 0, 1, 0, (n == 32) ? 32'd1 : 32'd0);
            chk("ready_u1", 1, 1, 0, (n == 32) ? 32'd1 : 32'd0);
            chk("ready_u2", 2, 1, 0, (n >= 8) ? 32'd1 : 32'd0);
            tick();
        end
    endtask

    initial begin : stimulus
        rst = 1'b1;
        idle_inputs();
        r_reg0 = '0; w_reg0 = '0; w_data0 = '0;
        r_reg1 = '0; w_reg1 = '0; w_data1 = '0;
        r_reg2 = '0; w_reg2 = '0; w_data2 = '0;
        repeat (2) tick();

        // Reset state
        r_reg0 = {5'd9, 5'd9};
        chk("rst_ready", 0, 1, 0, 32'd0);
        chk("rst_drop",  0, 2, 0, 32'd0);
        chk("rst_rd",    0, 0, 0, 32'd0);
        chk("rst_ready2", 2, 1, 0, 32'd0);
        tick();

        // Release reset: 32-cycle clear; a write attempt mid-clear is dropped
        rst = 1'b0;
        for (int n = 0; n <= 32; n++) begin
            regen0 = 1'b0;
            if (n == 3) begin
                regen0 = 1'b1; w_reg0 = 5'd2; w_data0 = 32'hCAFE_0002;
                r_reg0 = {5'd2, 5'd2};
                chk("clear_rd_blank", 0, 0, 0, 32'd0);
            end
            if (n == 4) chk("clear_drop", 0, 2, 0, 32'd1);
            if (n == 5) chk("clear_drop_end", 0, 2, 0, 32'd0);
            chk("ready_u0", 0, 1, 0, (n == 32) ? 32'd1 : 32'd0);
            chk("ready_u2", 2, 1, 0, (n >= 8) ? 32'd1 : 32'd0);
            tick();
        end
        idle_inputs();

        // Every entry reads 0 after the sweep
        for (int a = 0; a < 32; a++) begin
            r_reg0 = {5'(31 - a), 5'(a)};
            chk("clr_rd_p0", 0, 0, 0, 32'd0);
            chk("clr_rd_p1", 0, 0, 1, 32'd0);
            tick();
        end

        // Write r5 on u0 (bypass) and u1 (no bypass)
        regen0 = 1'b1; w_reg0 = 5'd5; w_data0 = 32'hDEAD_BEEF; r_reg0 = {5'd5, 5'd5};
        regen1 = 1'b1; w_reg1 = 5'd5; w_data1 = 32'hDEAD_BEEF; r_reg1 = {5'd5, 5'd5};
        chk("byp_r5_p0", 0, 0, 0, 32'hDEAD_BEEF);
        chk("byp_r5_p1", 0, 0, 1, 32'hDEAD_BEEF);
        chk("nobyp_r5",  1, 0, 0, 32'd0);
        tick();
        idle_inputs();
        chk("rd_r5_p0", 0, 0, 0, 32'hDEAD_BEEF);
        chk("rd_r5_p1", 0, 0, 1, 32'hDEAD_BEEF);
        chk("rd_r5_u1", 1, 0, 1, 32'hDEAD_BEEF);
        chk("r5_drop",  0, 2, 0, 32'd0);
        tick();

        // Same-cycle bypass of r7
        regen0 = 1'b1; w_reg0 = 5'd7; w_data0 = 32'h0000_1234; r_reg0 = {5'd5, 5'd7};
        regen1 = 1'b1; w_reg1 = 5'd7; w_data1 = 32'h0000_1234; r_reg1 = {5'd5, 5'd7};
        chk("byp_r7",     0, 0, 0, 32'h0000_1234);
        chk("byp_r5_oth", 0, 0, 1, 32'hDEAD_BEEF);
        chk("nobyp_r7",   1, 0, 0, 32'd0);
        tick();
        idle_inputs();
        chk("rd_r7_u0", 0, 0, 0, 32'h0000_1234);
        chk("rd_r7_u1", 1, 0, 0, 32'h0000_1234);
        tick();

        // Writes to r0 are discarded without a drop pulse
        regen0 = 1'b1; w_reg0 = 5'd0; w_data0 = 32'hFFFF_FFFF; r_reg0 = {5'd0, 5'd0};
        chk("r0_byp_blk", 0, 0, 0, 32'd0);
        tick();
        idle_inputs();
        chk("r0_rd_p0", 0, 0, 0, 32'd0);
        chk("r0_rd_p1", 0, 0, 1, 32'd0);
        chk("r0_drop",  0, 2, 0, 32'd0);
        tick();

        // Clear request after writing r3
        regen0 = 1'b1; w_reg0 = 5'd3; w_data0 = 32'h0000_00A5;
        tick();
        idle_inputs();
        clr0 = 1'b1; r_reg0 = {5'd3, 5'd3};
        chk("pre_clr_r3",    0, 0, 0, 32'h0000_00A5);
        chk("pre_clr_ready", 0, 1, 0, 32'd1);
        tick();
        clr0 = 1'b0;
        for (int m = 0; m <= 32; m++) begin
            regen0 = 1'b0; clr0 = 1'b0;
            r_reg0 = {5'd4, 5'd3};
            if (m == 0) begin regen0 = 1'b1; w_reg0 = 5'd4; w_data0 = 32'h0000_0044; end
            if (m == 1) chk("clr_wr_drop", 0, 2, 0, 32'd1);
            if (m == 2) chk("clr_drop_end", 0, 2, 0, 32'd0);
            if (m == 5) clr0 = 1'b1;
            if (m < 32) chk("clr_rd_blank", 0, 0, 0, 32'd0);
            chk("clr_ready", 0, 1, 0, (m == 32) ? 32'd1 : 32'd0);
            tick();
        end
        idle_inputs();
        chk("post_clr_r3", 0, 0, 0, 32'd0);
        chk("post_clr_r4", 0, 0, 1, 32'd0);
        tick();

        // Reset in the middle of a clear sweep (clr_ptr = 10)
        clr0 = 1'b1;
        tick();
        clr0 = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        chk("midclr_rst_ready", 0, 1, 0, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        ready_sweep();

        // 4-port, 8-entry instance
        regen2 = 1'b1;
        w_reg2 = 3'd1; w_data2 = 32'h0000_0011; tick();
        w_reg2 = 3'd2; w_data2 = 32'h0000_0022; tick();
        w_reg2 = 3'd3; w_data2 = 32'h0000_0033; tick();
        w_reg2 = 3'd6; w_data2 = 32'h0000_0066; tick();
        regen2 = 1'b0;
        r_reg2 = {3'd6, 3'd3, 3'd2, 3'd1};
        chk("u2_p0", 2, 0, 0, 32'h0000_0011);
        chk("u2_p1", 2, 0, 1, 32'h0000_0022);
        chk("u2_p2", 2, 0, 2, 32'h0000_0033);
        chk("u2_p3", 2, 0, 3, 32'h0000_0066);
        chk("u2_drop", 2, 2, 0, 32'd0);
        tick();
        regen2 = 1'b1; w_reg2 = 3'd7; w_data2 = 32'h0000_0077;
        r_reg2 = {3'd7, 3'd7, 3'd7, 3'd7};
        for (int k = 0; k < 4; k++) chk("u2_byp_r7", 2, 0, k, 32'h0000_0077);
        tick();
        regen2 = 1'b0;
        r_reg2 = {3'd7, 3'd7, 3'd6, 3'd0};
        chk("u2_r0", 2, 0, 0, 32'd0);
        chk("u2_r6", 2, 0, 1, 32'h0000_0066);
        chk("u2_r7", 2, 0, 3, 32'h0000_0077);
        tick();

        // Let the monitor drain, then confirm nothing was left unchecked
        @(negedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/banco_registros_param.md
Name: banco_registros_param

Overview:
- Clocked, parametrised register bank for the datapath. Replaces the combinational bank.
- Provides NUM_RD combinational read ports and one synchronous write port.
- Optional register-0 hardwiring and write-to-read bypass.
- Built-in clear sequencer zeroes every entry after reset or on request; no file preload.

Parameters:
- DATA_W, 32: width of each register and data bus.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2: number of read ports, 1..4.
- ZERO_REG, 1: when 1, entry 0 always reads 0 and writes to it are discarded.
- BYPASS, 1: when 1, a read of the address being written this cycle returns W_data.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- R_register  in  NUM_RD*ADDR_W  read addresses; port k is bits [k*ADDR_W +: ADDR_W].
- R_data  out  NUM_RD*DATA_W  read data; port k is bits [k*DATA_W +: DATA_W].
- W_register  in  ADDR_W  write address.
- W_data  in  DATA_W  write data.
- RegEn  in  1  write enable, sampled at the rising edge.
- Clr  in  1  synchronous clear request, single-cycle pulse.
- Ready  out  1  high when the bank accepts writes and holds valid data.
- Wr_drop  out  1  one-cycle pulse when a RegEn write is discarded.

Behaviour:
- Reset (asynchronous, active-high): FSM enters CLEAR with clr_ptr=0. Ready=0, Wr_drop=0. Array contents are not reset directly; the sequencer zeroes them.
- R_data during reset and CLEAR: all ports read 0, independent of array contents.
- FSM, two states:
  - CLEAR: each cycle writes 0 to entry clr_ptr, then clr_ptr++. When clr_ptr==DEPTH-1 is written, go to IDLE next cycle.
  - CLEAR duration: exactly DEPTH cycles after rst deasserts. Ready rises on cycle DEPTH+1.
  - IDLE: Ready=1. Clr=1 returns the FSM to CLEAR with clr_ptr=0 and drops Ready next cycle. The write sampled on the same edge as Clr is performed first.
  - Clr asserted during CLEAR: ignored; no restart.
- Write (IDLE only): on a rising edge with RegEn=1, MEM[W_register] <= W_data.
  - If ZERO_REG=1 and W_register==0, the write is discarded and Wr_drop does not pulse; this is an architectural no-op.
- RegEn=1 in CLEAR: write discarded; Wr_drop=1 on the following cycle.
- Read, combinational, per port k:
  - ZERO_REG=1 and address 0 -> 0.
  - Else BYPASS=1 and RegEn=1 and Ready=1 and R_register[k]==W_register -> W_data.
  - Else MEM[R_register[k]].
  - BYPASS=0: the new value is visible from the cycle after the write edge.
- Simultaneous reads of the same address on several ports return identical data.
- Reset during CLEAR or IDLE restarts CLEAR from entry 0.
- Widths: no arithmetic other than clr_ptr, which is ADDR_W+1 bits so wrap at DEPTH is detectable.

Decomposition:
- Shared package holds the FSM state typedef (ST_CLEAR, ST_IDLE) and the default constants DATA_W/ADDR_W.
- One natural sub-module, br_read_mux: one read port's zero/bypass/array select, instantiated NUM_RD times with a generate loop.
- Storage and the FSM stay in the top module.

Test Plan:
- Reset release, default params -> Ready=0 for 32 cycles, Ready=1 on cycle 33; reading all 32 addresses returns 0.
- IDLE: write 0xDEADBEEF to r5, then read r5 on port0 and port1 next cycle -> both return 0xDEADBEEF. Wr_drop stays 0.
- BYPASS=1: RegEn=1, W_register=7, W_data=0x1234, R_register port0=7 in the same cycle -> R_data port0=0x1234 before the edge. With BYPASS=0 -> old value (0).
- ZERO_REG=1: write 0xFFFFFFFF to r0, then read r0 -> 0; Wr_drop=0.
- Clr pulse after r3=0xA5 is written -> Ready low for 32 cycles; a RegEn write to r4 during CLEAR gives a Wr_drop pulse next cycle; after Ready=1, r3 and r4 read 0.
- Assert rst mid-CLEAR at clr_ptr=10 -> restart; Ready rises exactly DEPTH+1 cycles after rst deasserts. Repeat with NUM_RD=4, ADDR_W=3: 8-cycle clear, and 4 ports read distinct written values.
